// File: rtl/bsg_lfsr_keystream_pkg.sv
// rtl/bsg_lfsr_keystream_pkg.sv - shared types, default taps and single Galois step for the keystream LFSR
package bsg_lfsr_keystream_pkg;

  typedef enum logic [1:0] {
    eIdle,
    eRun,
    eExh
  } lfsr_state_e;

  localparam logic [31:0] default_poly_c = 32'h8020_0003;

  // Widest LFSR the step function supports; narrower states are zero-extended.
  localparam int max_width_c = 64;

  function automatic logic [max_width_c-1:0] galois_step(
    input logic [max_width_c-1:0] state,
    input logic [max_width_c-1:0] mask
  );
    galois_step = (state >> 1) ^ (state[0] ? mask : '0);
  endfunction

endpackage

// File: rtl/bsg_lfsr_step_n.sv
// rtl/bsg_lfsr_step_n.sv - combinational unroll of steps_p Galois LFSR steps
module bsg_lfsr_step_n
  import bsg_lfsr_keystream_pkg::*;
#(
  parameter int                 width_p = 32,
  parameter logic [width_p-1:0] poly_p  = width_p'(default_poly_c),
  parameter int                 steps_p = width_p
) (
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  logic [width_p-1:0] s;

  // The zero-extended upper bits never become nonzero, so truncation is lossless.
  always_comb begin
    s = data_i;
    for (int i = 0; i < steps_p; i++) begin
      s = width_p'(galois_step(max_width_c'(s), max_width_c'(poly_p)));
    end
    data_o = s;
  end

endmodule

// File: rtl/bsg_lfsr_keystream.sv
// rtl/bsg_lfsr_keystream.sv - seeded Galois LFSR keystream source with valid/yumi handshake and per-seed word budget
module bsg_lfsr_keystream
  import bsg_lfsr_keystream_pkg::*;
#(
  parameter int                 width_p          = 32,
  parameter logic [width_p-1:0] poly_p           = width_p'(default_poly_c),
  parameter int                 words_per_seed_p = 256,
  localparam int                count_width_lp   =
    (words_per_seed_p == 0) ? 1 : $clog2(words_per_seed_p + 1)
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      seed_v_i,
  input  logic [width_p-1:0]        seed_i,
  output logic                      v_o,
  output logic [width_p-1:0]        data_o,
  input  logic                      yumi_i,
  output logic                      exhausted_o,
  output logic [count_width_lp-1:0] count_o
);

  localparam logic [count_width_lp-1:0] count_max_lp = '1;
  localparam logic [count_width_lp-1:0] budget_lp    = count_width_lp'(words_per_seed_p);

  lfsr_state_e               state_q, state_d;
  logic [width_p-1:0]        lfsr_q, lfsr_d;
  logic [width_p-1:0]        lfsr_step;
  logic [width_p-1:0]        seed_fixed;
  logic [count_width_lp-1:0] count_q, count_d, count_inc;

  bsg_lfsr_step_n #(
    .width_p (width_p),
    .poly_p  (poly_p),
    .steps_p (width_p)
  ) step (
    .data_i (lfsr_q),
    .data_o (lfsr_step)
  );

  // All-zero is the LFSR's lock-up state.
  assign seed_fixed = (seed_i == '0) ? width_p'(1) : seed_i;
  assign count_inc  = count_q + count_width_lp'(1);

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    count_d = count_q;
    unique case (state_q)
      eIdle, eExh: begin
        if (seed_v_i) begin
          state_d = eRun;
          lfsr_d  = seed_fixed;
          count_d = '0;
        end
      end
      eRun: begin
        if (seed_v_i) begin
          lfsr_d  = seed_fixed;
          count_d = '0;
        end else if (yumi_i) begin
          lfsr_d = lfsr_step;
          if (words_per_seed_p == 0) begin
            if (count_q != count_max_lp) count_d = count_inc;
          end else begin
            count_d = count_inc;
            if (count_inc == budget_lp) state_d = eExh;
          end
        end
      end
      default: state_d = eIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= eIdle;
      lfsr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      count_q <= count_d;
    end
  end

  assign v_o         = (state_q == eRun);
  assign exhausted_o = (state_q == eExh);
  assign data_o      = lfsr_q;
  assign count_o     = count_q;

  yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);

endmodule

// File: tb/tb_bsg_lfsr_keystream.sv
// tb/tb_bsg_lfsr_keystream.sv - directed self-checking bench for bsg_lfsr_keystream
module tb_bsg_lfsr_keystream;

  logic        clk;
  logic        reset_n;
  logic        seed_v;
  logic [31:0] seed;
  logic        yumi_a, yumi_b, yumi_c;

  logic        v_a, v_b, v_c;
  logic [31:0] data_a, data_b, data_c;
  logic        exh_a, exh_b, exh_c;
  logic [8:0]  count_a;
  logic [2:0]  count_b;
  logic [0:0]  count_c;

  int checks = 0;
  int failures = 0;

  bsg_lfsr_keystream dut_a (
    .clk_i(clk), .reset_n_i(reset_n), .seed_v_i(seed_v), .seed_i(seed),
    .v_o(v_a), .data_o(data_a), .yumi_i(yumi_a), .exhausted_o(exh_a), .count_o(count_a)
  );

  bsg_lfsr_keystream #(.words_per_seed_p(4)) dut_b (
    .clk_i(clk), .reset_n_i(reset_n), .seed_v_i(seed_v), .seed_i(seed),
    .v_o(v_b), .data_o(data_b), .yumi_i(yumi_b), .exhausted_o(exh_b), .count_o(count_b)
  );

  bsg_lfsr_keystream #(.words_per_seed_p(0)) dut_c (
    .clk_i(clk), .reset_n_i(reset_n), .seed_v_i(seed_v), .seed_i(seed),
    .v_o(v_c), .data_o(data_c), .yumi_i(yumi_c), .exhausted_o(exh_c), .count_o(count_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] s);
    logic lsb;
    for (int i = 0; i < 32; i++) begin
      lsb = s[0];
      s   = {1'b0, s[31:1]};
      if (lsb) s = s ^ 32'h8020_0003;
    end
    return s;
  endfunction

  logic [31:0] exp_word;
  logic [31:0] a_word;

  initial begin
    reset_n = 1'b0;
    seed_v  = 1'b0;
    seed    = '0;
    yumi_a  = 1'b0;
    yumi_b  = 1'b0;
    yumi_c  = 1'b0;
    a_word  = 32'hFFFF_FFFF;
    repeat (3) tick();
    reset_n = 1'b1;

    // idle after reset, no seed
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_v", 32'(v_a), 32'd0);
      chk("idle_exh", 32'(exh_a), 32'd0);
      chk("idle_count", 32'(count_a), 32'd0);
      chk("idle_data", data_a, 32'd0);
    end

    // seed and first words
    seed_v = 1'b1;
    seed   = 32'hDEAD_BEEF;
    tick();
    seed_v = 1'b0;
    chk("seed_v", 32'(v_a), 32'd1);
    chk("seed_data", data_a, 32'hDEAD_BEEF);
    chk("seed_count", 32'(count_a), 32'd0);
    exp_word = 32'hDEAD_BEEF;
    yumi_a = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      exp_word = ref_word(exp_word);
      chk("chain_data", data_a, exp_word);
      chk("chain_count", 32'(count_a), 32'(i));
      chk("chain_v", 32'(v_a), 32'd1);
      chk("xor_out", a_word ^ data_a, ~exp_word);
    end
    yumi_a = 1'b0;

    // zero seed and backpressure
    seed_v = 1'b1;
    seed   = 32'h0;
    tick();
    seed_v = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("zero_seed_data", data_a, 32'h0000_0001);
      chk("zero_seed_count", 32'(count_a), 32'd0);
      tick();
    end

    // one beat from seed 1, then seed and yumi together
    yumi_a = 1'b1;
    tick();
    chk("one_data", data_a, ref_word(32'h1));
    chk("one_count", 32'(count_a), 32'd1);
    seed_v = 1'b1;
    seed   = 32'h0F0F_0F0F;
    tick();
    seed_v = 1'b0;
    yumi_a = 1'b0;
    chk("simul_data", data_a, 32'h0F0F_0F0F);
    chk("simul_count", 32'(count_a), 32'd0);
    chk("simul_v", 32'(v_a), 32'd1);

    // exhaustion with a budget of four words
    seed_v = 1'b1;
    seed   = 32'h1234_5678;
    tick();
    seed_v = 1'b0;
    chk("exh_seed_data", data_b, 32'h1234_5678);
    exp_word = 32'h1234_5678;
    yumi_b = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      exp_word = ref_word(exp_word);
      if (i == 4) yumi_b = 1'b0;
      chk("exh_chain_count", 32'(count_b), 32'(i));
      chk("exh_chain_data", data_b, exp_word);
    end
    chk("exh_flag", 32'(exh_b), 32'd1);
    chk("exh_v", 32'(v_b), 32'd0);
    repeat (2) tick();
    chk("exh_hold_data", data_b, exp_word);
    chk("exh_hold_count", 32'(count_b), 32'd4);
    chk("exh_hold_flag", 32'(exh_b), 32'd1);
    seed_v = 1'b1;
    seed   = 32'hA5A5_A5A5;
    tick();
    seed_v = 1'b0;
    chk("reseed_v", 32'(v_b), 32'd1);
    chk("reseed_data", data_b, 32'hA5A5_A5A5);
    chk("reseed_count", 32'(count_b), 32'd0);
    chk("reseed_exh", 32'(exh_b), 32'd0);

    // unlimited budget saturates the 1-bit counter and never exhausts
    yumi_c = 1'b1;
    repeat (3) tick();
    yumi_c = 1'b0;
    chk("unl_count", 32'(count_c), 32'd1);
    chk("unl_v", 32'(v_c), 32'd1);
    chk("unl_exh", 32'(exh_c), 32'd0);
    chk("unl_data", data_c, ref_word(ref_word(ref_word(32'hA5A5_A5A5))));

    // asynchronous reset mid-cycle while streaming
    chk("pre_rst_v", 32'(v_a), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_v", 32'(v_a), 32'd0);
    chk("rst_data", data_a, 32'd0);
    chk("rst_count", 32'(count_a), 32'd0);
    chk("rst_v_b", 32'(v_b), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("post_rst_v", 32'(v_a), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bsg_lfsr_keystream.md
Name: bsg_lfsr_keystream

Overview:
- Produces a stream of 32-bit pseudo-random keystream words from a seeded Galois LFSR.
- Sits directly upstream of the bitwise XOR stage and drives its b_i operand; the XOR combines a_i data with the keystream to scramble or descramble it.
- Handshake is valid/yumi, so the consumer pops one word per accepted beat.
- Re-seeds on request and stops after a programmable number of words per seed.

Parameters:
- width_p, 32: keystream word width and LFSR state width.
- poly_p, 32'h8020_0003: Galois tap mask, applied when the shifted-out LSB is 1.
- words_per_seed_p, 256: words emitted per seed before stopping. 0 means unlimited.

Ports:
- clk_i  in  1  clock, all state updates on rising edge.
- reset_n_i  in  1  reset, asynchronous and active-low.
- seed_v_i  in  1  load seed_i this cycle. Always accepted, no ready.
- seed_i  in  width_p  seed value.
- v_o  out  1  data_o holds a valid keystream word.
- data_o  out  width_p  current keystream word, registered.
- yumi_i  in  1  consumer takes data_o this cycle. Legal only when v_o=1.
- exhausted_o  out  1  seed budget used up; awaiting a new seed.
- count_o  out  $clog2(words_per_seed_p+1)  words consumed since last seed. Width is 1 bit when words_per_seed_p=0.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - FSM to IDLE.
  - LFSR state = 0, data_o = 0.
  - v_o = 0, exhausted_o = 0, count_o = 0.
- Galois step: s' = (s>>1) ^ (s[0] ? poly_p : 0).
- Word advance: step32 = 32 consecutive single steps, unrolled combinationally. One word advance per accepted beat.
- data_o is the LFSR state register; there is no separate output register.
- A seed of 0 is replaced by 1, because the zero state locks up the LFSR.
- FSM states:
  - IDLE: v_o=0. seed_v_i -> RUN, state=seed, count=0.
  - RUN: v_o=1.
    - yumi_i & ~seed_v_i: state=step32(state), count+1. If count+1 == words_per_seed_p (nonzero), go to EXH.
    - seed_v_i: state=seed, count=0, stay in RUN. Seed has priority; a simultaneous yumi still counts as a consumed beat on the consumer side but does not advance the LFSR.
  - EXH: v_o=0, exhausted_o=1, state is held. seed_v_i -> RUN, state=seed, count=0, exhausted_o=0.
- Latency: seed accepted at edge t gives v_o=1 and data_o=seed (or 1 if seed was 0) after edge t. Zero bubble between consecutive words; full throughput of one word per cycle.
- words_per_seed_p=0: never enters EXH; count_o saturates at its maximum.
- yumi_i with v_o=0: ignored; assertion failure in simulation.
- Reset asserted mid-stream: immediate return to IDLE; the in-flight word is discarded.
- Outputs depend only on registers; no combinational input-to-output path.

Decomposition:
- Package bsg_lfsr_keystream_pkg:
  - FSM enum {eIdle, eRun, eExh}.
  - Default tap-mask constant.
  - Function for the single Galois step.
- Sub-module bsg_lfsr_step_n:
  - Purely combinational, parameters width_p, poly_p, steps_p.
  - Applies steps_p Galois steps; instantiated with steps_p = width_p.
  - Reusable by the matching descrambler.

Test Plan:
- Reset then idle: reset_n_i low then high, no seed -> v_o=0, exhausted_o=0, count_o=0 for 20 cycles; yumi_i held 0.
- Seed and first word: seed 32'hDEAD_BEEF at cycle 5 -> cycle 6 v_o=1, data_o=32'hDEAD_BEEF. Hold yumi_i=1 for 4 cycles -> data_o follows golden step32 chain each cycle; count_o = 1, 2, 3, 4.
- Zero seed and backpressure: seed 0 -> data_o=32'h0000_0001. yumi_i=0 for 10 cycles -> data_o stable, count_o=0.
- Exhaustion with words_per_seed_p=4: seed 32'h1234_5678, 4 yumis -> exhausted_o=1, v_o=0, count_o=4. New seed 32'hA5A5_A5A5 -> v_o=1, data_o=32'hA5A5_A5A5, count_o=0.
- Simultaneous seed and yumi in RUN: seed 32'h0F0F_0F0F with yumi_i=1 -> next data_o=32'h0F0F_0F0F, count_o=0.
- Reset mid-stream: assert reset_n_i low asynchronously mid-cycle while v_o=1 -> v_o drops to 0 without waiting for a clock edge; data_o=0.
- End to end: feed data_o into the XOR with a_i=32'hFFFF_FFFF -> XOR output = ~data_o every beat.
